// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate format tags and helpers for the
// immediate-generation stage.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE    = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_INVALID = 3'd7
  } imm_fmt_e;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  // funct3 values of SLLI (001) and SRLI/SRAI (101)
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: format classification, immediate
// extraction and XLEN sign extension for one instruction word.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic            is_nop
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  imm_fmt_e    w_fmt;
  logic [31:0] w_imm32;

  assign w_opc = instr[6:0];
  assign w_f3  = instr[14:12];

  always_comb begin
    w_fmt = FMT_INVALID;
    case (w_opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_JALR, OPC_SYSTEM: w_fmt = FMT_I;
      OPC_OP_IMM: w_fmt = (SHAMT_ZEXT && is_shift_f3(w_f3)) ? FMT_SHAMT : FMT_I;
      OPC_OP_IMM_32: begin
        if (XLEN == 64) w_fmt = (SHAMT_ZEXT && is_shift_f3(w_f3)) ? FMT_SHAMT : FMT_I;
      end
      OPC_STORE:          w_fmt = FMT_S;
      OPC_BRANCH:         w_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
      OPC_JAL:            w_fmt = FMT_J;
      OPC_OP:             w_fmt = FMT_NONE;
      OPC_OP_32: begin
        if (XLEN == 64) w_fmt = FMT_NONE;
      end
      default: w_fmt = FMT_INVALID;
    endcase
  end

  // Shift amounts keep bit 31 clear, so the shared sign extension below
  // degenerates into zero extension for them.
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I: w_imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: w_imm32 = {instr[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_SHAMT: begin
        if (XLEN == 64 && w_opc == OPC_OP_IMM) w_imm32 = {26'b0, instr[25:20]};
        else                                   w_imm32 = {27'b0, instr[24:20]};
      end
      default: w_imm32 = '0;
    endcase
  end

  assign imm[31:0] = w_imm32;

  genvar gi;
  generate
    for (gi = 32; gi < XLEN; gi++) begin : g_sext
      assign imm[gi] = w_imm32[31];
    end
  endgenerate

  assign fmt     = w_fmt;
  assign illegal = (w_fmt == FMT_INVALID);
  assign is_nop  = (instr == NOP_WORD);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decode on the input side, then an
// output register backed by a one-entry skid register with valid/ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit SHAMT_ZEXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_in,
  input  logic            instr_valid_in,
  output logic            instr_ready_out,
  input  logic [31:0]     instr_in,
  output logic            imm_valid_out,
  input  logic            imm_ready_in,
  output logic [XLEN-1:0] imm_value_out,
  output logic [2:0]      imm_fmt_out,
  output logic            illegal_out,
  output logic            is_nop_out,
  output logic [31:0]     instr_out
);

  localparam int EW = XLEN + 37;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;
  logic            w_dec_illegal;
  logic            w_dec_nop;
  logic [EW-1:0]   w_dec_entry;

  logic [1:0]      r_state;
  logic            r_ready;
  logic [EW-1:0]   r_out_entry;
  logic [EW-1:0]   r_skid_entry;

  logic            w_accept;
  logic            w_drain;

  imm_decode #(
    .XLEN       (XLEN),
    .SHAMT_ZEXT (SHAMT_ZEXT)
  ) u_decode (
    .instr   (instr_in),
    .imm     (w_dec_imm),
    .fmt     (w_dec_fmt),
    .illegal (w_dec_illegal),
    .is_nop  (w_dec_nop)
  );

  // Entry layout, MSB first: imm | fmt | illegal | is_nop | instr
  assign w_dec_entry = {w_dec_imm, w_dec_fmt, w_dec_illegal, w_dec_nop, instr_in};

  assign w_accept = instr_valid_in & r_ready;
  assign w_drain  = (r_state != ST_EMPTY) & imm_ready_in;

  // Ready depends only on occupancy, never on this cycle's imm_ready_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_ready      <= 1'b1;
      r_out_entry  <= '0;
      r_skid_entry <= '0;
    end else if (flush_in) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out_entry <= w_dec_entry;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_drain) begin
            r_skid_entry <= w_dec_entry;
            r_state      <= ST_FULL;
            r_ready      <= 1'b0;
          end else if (w_accept && w_drain) begin
            r_out_entry <= w_dec_entry;
          end else if (w_drain) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            r_out_entry <= r_skid_entry;
            r_state     <= ST_ONE;
            r_ready     <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready_out = r_ready;
  assign imm_valid_out   = (r_state != ST_EMPTY);
  assign imm_value_out   = r_out_entry[EW-1:37];
  assign imm_fmt_out     = r_out_entry[36:34];
  assign illegal_out     = r_out_entry[33];
  assign is_nop_out      = r_out_entry[32];
  assign instr_out       = r_out_entry[31:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit (shamt zero-extend) and a
// 64-bit (shamt as I-type) instance driven by the same stimulus.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        flush_in = 1'b0;
  logic        instr_valid_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic        imm_ready_in;

  logic        rdy32, vld32, ill32, nop32;
  logic [31:0] imm32, io32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64, nop64;
  logic [63:0] imm64;
  logic [31:0] io64;
  logic [2:0]  fmt64;

  int n_cmp  = 0;
  int n_fail = 0;

  logic bp_mode   = 1'b0;
  logic ready_req = 1'b0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] i32;
    logic [2:0]  f32;
    logic [63:0] i64;
    logic [2:0]  f64;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic        nop;
  } exp_t;

  vec_t vecs[14];
  exp_t q32[$];
  exp_t q64[$];

  imm_gen_pipe #(.XLEN(32), .SHAMT_ZEXT(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush_in(flush_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(rdy32), .instr_in(instr_in),
    .imm_valid_out(vld32), .imm_ready_in(imm_ready_in), .imm_value_out(imm32),
    .imm_fmt_out(fmt32), .illegal_out(ill32), .is_nop_out(nop32), .instr_out(io32)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_ZEXT(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush_in(flush_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(rdy64), .instr_in(instr_in),
    .imm_valid_out(vld64), .imm_ready_in(imm_ready_in), .imm_value_out(imm64),
    .imm_fmt_out(fmt64), .illegal_out(ill64), .is_nop_out(nop64), .instr_out(io64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sole driver of imm_ready_in; random when bp_mode is set.
  initial begin
    imm_ready_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      imm_ready_in = bp_mode ? 1'($urandom_range(0, 1)) : ready_req;
    end
  end

  initial begin : mon32
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld32 === 1'b1 && imm_ready_in === 1'b1) begin
        if (q32.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL d32_unexpected: got instr 0x%08h expected no output", io32);
        end else begin
          e = q32.pop_front();
          chk("d32_instr", {32'b0, io32}, {32'b0, e.instr});
          chk("d32_imm", {32'b0, imm32}, e.imm);
          chk("d32_fmt", {61'b0, fmt32}, {61'b0, e.fmt});
          chk("d32_ill", {63'b0, ill32}, {63'b0, e.ill});
          chk("d32_nop", {63'b0, nop32}, {63'b0, e.nop});
          $display("txn d32 instr=%08h imm=%08h fmt=%0d ill=%0b nop=%0b", io32, imm32, fmt32, ill32, nop32);
        end
      end
    end
  end

  initial begin : mon64
    exp_t e;
    forever begin
      @(negedge clk);
      if (vld64 === 1'b1 && imm_ready_in === 1'b1) begin
        if (q64.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL d64_unexpected: got instr 0x%08h expected no output", io64);
        end else begin
          e = q64.pop_front();
          chk("d64_instr", {32'b0, io64}, {32'b0, e.instr});
          chk("d64_imm", imm64, e.imm);
          chk("d64_fmt", {61'b0, fmt64}, {61'b0, e.fmt});
          chk("d64_ill", {63'b0, ill64}, {63'b0, e.ill});
          chk("d64_nop", {63'b0, nop64}, {63'b0, e.nop});
          $display("txn d64 instr=%08h imm=%016h fmt=%0d ill=%0b nop=%0b", io64, imm64, fmt64, ill64, nop64);
        end
      end
    end
  end

  task automatic push(input int k);
    exp_t e;
    e.instr = vecs[k].instr;
    e.nop   = (vecs[k].instr == 32'h00000013);
    e.imm   = {32'b0, vecs[k].i32};
    e.fmt   = vecs[k].f32;
    e.ill   = (vecs[k].f32 == 3'd7);
    q32.push_back(e);
    e.imm   = vecs[k].i64;
    e.fmt   = vecs[k].f64;
    e.ill   = (vecs[k].f64 == 3'd7);
    q64.push_back(e);
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int k);
    int waited;
    waited = 0;
    instr_valid_in = 1'b1;
    instr_in = vecs[k].instr;
    @(negedge clk);
    while (rdy32 !== 1'b1) begin
      waited++;
      if (waited > 60) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: instr 0x%08h ready=%0b expected 1", vecs[k].instr, rdy32);
        instr_valid_in = 1'b0;
        return;
      end
      @(negedge clk);
    end
    push(k);
    @(posedge clk);
    #1;
    instr_valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while ((q32.size() != 0 || q64.size() != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (q32.size() != 0 || q64.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: got %0d/%0d pending expected 0/0", tag, q32.size(), q64.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_rdy32"}, {63'b0, rdy32}, 64'd1);
    chk({tag, "_vld32"}, {63'b0, vld32}, 64'd0);
    chk({tag, "_imm32"}, {32'b0, imm32}, 64'd0);
    chk({tag, "_fmt32"}, {61'b0, fmt32}, 64'd0);
    chk({tag, "_ill32"}, {63'b0, ill32}, 64'd0);
    chk({tag, "_nop32"}, {63'b0, nop32}, 64'd0);
    chk({tag, "_io32"}, {32'b0, io32}, 64'd0);
    chk({tag, "_rdy64"}, {63'b0, rdy64}, 64'd1);
    chk({tag, "_vld64"}, {63'b0, vld64}, 64'd0);
    chk({tag, "_imm64"}, imm64, 64'd0);
    chk({tag, "_io64"}, {32'b0, io64}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1}; // addi -1
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3}; // beq -4
    vecs[2]  = '{32'h123452B7, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4}; // lui
    vecs[3]  = '{32'h0020A423, 32'h00000008, 3'd2, 64'h0000000000000008, 3'd2}; // sw 8
    vecs[4]  = '{32'h4030D093, 32'h00000003, 3'd6, 64'h0000000000000403, 3'd1}; // srai 3
    vecs[5]  = '{32'h0000007F, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7}; // illegal
    vecs[6]  = '{32'h00000013, 32'h00000000, 3'd1, 64'h0000000000000000, 3'd1}; // nop
    vecs[7]  = '{32'h008000EF, 32'h00000008, 3'd5, 64'h0000000000000008, 3'd5}; // jal +8
    vecs[8]  = '{32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2}; // sw -4
    vecs[9]  = '{32'h003100B3, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0}; // add
    vecs[10] = '{32'hFFF0809B, 32'h00000000, 3'd7, 64'hFFFFFFFFFFFFFFFF, 3'd1}; // addiw -1
    vecs[11] = '{32'h02009093, 32'h00000000, 3'd6, 64'h0000000000000020, 3'd1}; // slli 32
    vecs[12] = '{32'hFFFFF017, 32'hFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF000, 3'd4}; // auipc
    vecs[13] = '{32'h800080E7, 32'hFFFFF800, 3'd1, 64'hFFFFFFFFFFFFF800, 3'd1}; // jalr -2048

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_cleared("reset");

    // Streaming with ready held high: one word per cycle.
    @(posedge clk);
    #1;
    ready_req = 1'b1;
    send(0);
    @(negedge clk);
    chk("latency_valid", {63'b0, vld32}, 64'd1);
    chk("latency_instr", {32'b0, io32}, {32'b0, vecs[0].instr});
    @(posedge clk);
    #1;
    for (int k = 1; k < 14; k++) send(k);
    drain("stream");

    // Random downstream backpressure.
    bp_mode = 1'b1;
    for (int k = 0; k < 14; k++) send(k);
    drain("random_bp");
    bp_mode = 1'b0;

    // A, B, C back-to-back into a stalled consumer.
    ready_req = 1'b0;
    @(posedge clk);
    #1;
    send(2);
    send(3);
    instr_valid_in = 1'b1;
    instr_in = vecs[7].instr;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("full_ready32", {63'b0, rdy32}, 64'd0);
      chk("full_ready64", {63'b0, rdy64}, 64'd0);
      chk("full_hold_instr", {32'b0, io32}, {32'b0, vecs[2].instr});
      chk("full_hold_imm", {32'b0, imm32}, 64'h12345000);
    end
    @(posedge clk);
    #1;
    ready_req = 1'b1;
    send(7);
    drain("abc");

    // Flush while FULL with C offered: nothing survives.
    ready_req = 1'b0;
    @(posedge clk);
    #1;
    send(5);
    send(8);
    instr_valid_in = 1'b1;
    instr_in = vecs[9].instr;
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    instr_valid_in = 1'b0;
    q32.delete();
    q64.delete();
    @(negedge clk);
    chk("flush_valid32", {63'b0, vld32}, 64'd0);
    chk("flush_ready32", {63'b0, rdy32}, 64'd1);
    chk("flush_valid64", {63'b0, vld64}, 64'd0);
    chk("flush_ready64", {63'b0, rdy64}, 64'd1);
    @(posedge clk);
    #1;
    ready_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("flush_idle", {63'b0, vld32}, 64'd0);

    // Flush while EMPTY drops the word offered in the same cycle.
    @(posedge clk);
    #1;
    instr_valid_in = 1'b1;
    instr_in = vecs[3].instr;
    flush_in = 1'b1;
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    instr_valid_in = 1'b0;
    @(negedge clk);
    chk("flush_drop", {63'b0, vld32}, 64'd0);
    @(posedge clk);
    #1;
    send(13);
    drain("after_flush");

    // Reset in the middle of a FULL pipeline clears everything.
    ready_req = 1'b0;
    @(posedge clk);
    #1;
    send(5);
    send(7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q32.delete();
    q64.delete();
    @(negedge clk);
    chk_cleared("midrst");
    @(posedge clk);
    #1;
    ready_req = 1'b1;
    send(0);
    drain("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, handshaked immediate-generation stage for the RV32I/RV64I decode path, a successor to the combinational immediate selector.
- Decodes all base immediate formats with correct sign extension to XLEN.
- Flags shift-amount immediates, canonical NOPs and illegal opcodes.
- Sits between fetch and register-read with valid/ready on both sides and a 2-entry skid buffer, so fetch is never stalled combinationally by downstream backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHAMT_ZEXT, 1, 1: SLLI/SRLI/SRAI immediate = shamt zero-extended; 0: treat them as plain I-type.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_in  in  1  synchronous pipeline flush.
- instr_valid_in  in  1  upstream valid.
- instr_ready_out  out  1  upstream ready (registered).
- instr_in  in  32  instruction word.
- imm_valid_out  out  1  downstream valid.
- imm_ready_in  in  1  downstream ready.
- imm_value_out  out  XLEN  decoded immediate.
- imm_fmt_out  out  3  format tag.
- illegal_out  out  1  opcode not recognised.
- is_nop_out  out  1  instr == 0x00000013.
- instr_out  out  32  instruction passthrough, aligned with imm_value_out.

Behaviour:
- Reset (rst=1 at clk edge):
  - imm_valid_out=0, instr_ready_out=1, imm_value_out=0, imm_fmt_out=0, illegal_out=0, is_nop_out=0, instr_out=0.
  - Skid entry invalid. rst overrides all other inputs.
- Format tags: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 INVALID.
- Opcode map:
  - I: LOAD 0000011, OP_IMM 0010011, JALR 1100111, MISC_MEM 0001111, SYSTEM 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: 1101111.
  - NONE: OP 0110011, imm=0.
  - RV64 only, when XLEN=64: OP_IMM_32 0011011 is I-type; OP_32 0111011 is NONE.
- Immediate construction (sx = sign-extend bit 31 to XLEN):
  - I: sx(i[31:20]).
  - S: sx({i[31:25],i[11:7]}).
  - B: sx({i[31],i[7],i[30:25],i[11:8],0}).
  - U: sx({i[31:12],12'b0}).
  - J: sx({i[31],i[19:12],i[20],i[30:21],0}).
- SHAMT applies when SHAMT_ZEXT=1, opcode is OP_IMM (or OP_IMM_32) and funct3 is 001 or 101.
  - Immediate = zero-extended i[24:20] for XLEN=32 or OP_IMM_32; i[25:20] for XLEN=64 OP_IMM.
- Unrecognised opcode: imm=0, fmt=7, illegal_out=1; the word is still transferred.
- is_nop_out=1 only for instr exactly 0x00000013.
- Latency: 1 cycle. Instruction accepted at edge N appears on the outputs after edge N when the output register is free.
- Handshake rules:
  - A transfer occurs when valid and ready are both high at the clock edge.
  - Once imm_valid_out=1, the outputs hold stable until imm_ready_in=1.
  - Order is strictly preserved.
- State machine on occupancy:
  - EMPTY: out reg invalid. Accept moves to ONE.
  - ONE: out reg valid.
    - Accept with no drain: write skid, go to FULL, instr_ready_out=0 next cycle.
    - Drain with no accept: go to EMPTY.
    - Accept and drain together: new word goes to out reg, stay in ONE.
  - FULL: instr_ready_out=0.
    - Drain: skid moves to out reg, go to ONE, instr_ready_out=1 next cycle.
  - instr_ready_out is a pure register output, with no combinational path from imm_ready_in.
- Flush:
  - flush_in=1 at an edge invalidates out reg and skid and goes to EMPTY with instr_ready_out=1.
  - A word offered that cycle is dropped.
  - Data outputs may hold stale values while imm_valid_out=0.
- Reset asserted mid-operation: same result as flush, plus the data outputs clear to 0.

Decomposition:
- Package imm_pkg holds:
  - opcode localparams (OPC_LOAD … OPC_OP_32);
  - the imm_fmt_e enum (3-bit) with the tags above;
  - NOP_WORD = 32'h00000013.
- Sub-module imm_decode: purely combinational, parameter XLEN and SHAMT_ZEXT.
  - Inputs: instr.
  - Outputs: imm, fmt, illegal, is_nop.
  - Instantiated once on the input side; imm_gen_pipe holds only the state machine, output register and skid register.

Test Plan:
- XLEN=32: 0xFFF00093 (addi x1,x0,-1), then 0xFE000EE3 (beq -4), with imm_ready_in=1 → next cycle imm 0xFFFFFFFF fmt 1, then imm 0xFFFFFFFC fmt 3, one per cycle.
- 0x123452B7 (lui x5,0x12345) → imm 0x12345000 fmt 4. 0x0020A423 (sw x2,8(x1)) → imm 0x00000008 fmt 2.
- 0x4030D093 (srai x1,x1,3): with SHAMT_ZEXT=1 → imm 3 fmt 6; with SHAMT_ZEXT=0 → imm 0x00000403 fmt 1. 0x0000007F → illegal 1, imm 0, fmt 7.
- 0x00000013 → is_nop 1, fmt 1, imm 0. XLEN=64: 0xFFF00093 → imm 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold imm_ready_in=0 and offer A, B, C back-to-back → A on output, B in skid, instr_ready_out=0 from the cycle after B, C held. Release → A, B, C delivered in order, one per cycle.
- Flush in FULL while C is offered → imm_valid_out=0 next cycle, instr_ready_out=1, C never appears. Then rst mid-stream → all outputs 0 and instr_ready_out=1.
